// File: rtl/adc_frame_packer.sv
// adc_frame_packer: buffers ADC samples in a small FIFO and packs each frame into
// a byte stream: A5 5A seq {hi lo}*N csum, with csum inverted on a truncated frame.
module adc_frame_packer #(
    parameter int DATA_WIDTH    = 12,
    parameter int FRAME_SAMPLES = 1024,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_first,
    output logic                  s_ready,
    output logic [7:0]            m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  overflow,
    output logic                  trunc_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FRAME_SAMPLES) + 1;
    localparam int EW = DATA_WIDTH + 1;

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, SEQ, DATA_HI, DATA_LO, CSUM} state_t;

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          s_ready_q, overflow_q;

    state_t        state_q;
    logic [7:0]    seq_q, csum_q, m_data_q;
    logic [CW-1:0] cnt_q;
    logic          trunc_q, m_valid_q, m_last_q, trunc_err_q;

    logic          empty, full, wr, pop, can_load, emit, trunc_now, head_first, out_last;
    logic [15:0]   head16;
    logic [7:0]    out_byte;

    always_comb begin
        empty      = count_q == '0;
        full       = count_q == (AW+1)'(FIFO_DEPTH);
        wr         = s_valid && !full;
        head_first = mem_q[rd_ptr_q][DATA_WIDTH];
        head16     = 16'(mem_q[rd_ptr_q][DATA_WIDTH-1:0]);
        can_load   = !m_valid_q || m_ready;
        trunc_now  = state_q == DATA_HI && !empty && cnt_q != '0 && head_first;
        emit       = can_load && state_q != IDLE && !(state_q == DATA_HI && (empty || trunc_now));
        out_last   = state_q == CSUM;
        out_byte   = state_q == HDR0    ? 8'hA5 :
                     state_q == HDR1    ? 8'h5A :
                     state_q == SEQ     ? seq_q :
                     state_q == DATA_HI ? head16[15:8] :
                     state_q == DATA_LO ? head16[7:0] :
                     trunc_q            ? ~csum_q : csum_q;
        pop        = (state_q == IDLE && !empty && !head_first) || (state_q == DATA_LO && emit);
        count_d    = count_q + (AW+1)'(wr) - (AW+1)'(pop);
    end

    // s_ready leaves one spare entry for a conversion already in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            s_ready_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (wr) begin
                mem_q[wr_ptr_q] <= {s_first, s_data};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            s_ready_q  <= count_d <= (AW+1)'(FIFO_DEPTH - 2);
            overflow_q <= overflow_q || (s_valid && full);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            seq_q       <= '0;
            csum_q      <= '0;
            cnt_q       <= '0;
            trunc_q     <= 1'b0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            trunc_err_q <= 1'b0;
        end else begin
            if (emit) begin
                m_data_q  <= out_byte;
                m_valid_q <= 1'b1;
                m_last_q  <= out_last;
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE:    if (!empty && head_first) state_q <= HDR0;
                HDR0:    if (emit) state_q <= HDR1;
                HDR1:    if (emit) state_q <= SEQ;
                SEQ: if (emit) begin
                    csum_q  <= seq_q;
                    cnt_q   <= '0;
                    state_q <= DATA_HI;
                end
                // a new first sample mid-frame closes this frame and stays at head
                DATA_HI: if (trunc_now) begin
                    trunc_q <= 1'b1;
                    state_q <= CSUM;
                end else if (emit) begin
                    csum_q  <= csum_q + out_byte;
                    state_q <= DATA_LO;
                end
                DATA_LO: if (emit) begin
                    csum_q  <= csum_q + out_byte;
                    cnt_q   <= cnt_q + 1'b1;
                    state_q <= cnt_q == CW'(FRAME_SAMPLES - 1) ? CSUM : DATA_HI;
                end
                CSUM: if (emit) begin
                    trunc_err_q <= trunc_err_q || trunc_q;
                    trunc_q     <= 1'b0;
                    seq_q       <= seq_q + 8'd1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_ready   = s_ready_q;
    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign overflow  = overflow_q;
    assign trunc_err = trunc_err_q;
endmodule
